// File: rtl/universal_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_pkg
//   Shared definitions for the universal shift register:
//   - usr_mode_e : the four operating modes (hold / shift right / shift left /
//                  parallel load). The encodings are fixed because they form
//                  the external mode bus.
//   - cnt_width  : width of a counter that must be able to hold WIDTH itself.
// -----------------------------------------------------------------------------
package universal_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  // The counter saturates at WIDTH, so it needs room for WIDTH, not WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : universal_shift_reg_pkg

// File: rtl/universal_shift_reg_if.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_if
//   Bus bundle for the universal shift register.
//   master (the driver, e.g. a controller or testbench):
//     out: mode, data, ser_in_r, ser_in_l
//     in : Q, ser_out_r, ser_out_l, shift_cnt, done
//   slave (the shift register itself): directions mirrored.
//   Parameter WIDTH must match the WIDTH of the attached register.
// -----------------------------------------------------------------------------
interface universal_shift_reg_if #(
  parameter int WIDTH = 4
) ();
  import universal_shift_reg_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  usr_mode_e          mode;       // operating mode
  logic [WIDTH-1:0]   data;       // parallel load value
  logic               ser_in_r;   // enters at MSB on shift right
  logic               ser_in_l;   // enters at LSB on shift left
  logic [WIDTH-1:0]   Q;          // register contents
  logic               ser_out_r;  // Q[0]
  logic               ser_out_l;  // Q[WIDTH-1]
  logic [CNT_W-1:0]   shift_cnt;  // shifts since last load/reset, saturating
  logic               done;       // shift_cnt == WIDTH

  modport master (
    output mode, data, ser_in_r, ser_in_l,
    input  Q, ser_out_r, ser_out_l, shift_cnt, done
  );

  modport slave (
    input  mode, data, ser_in_r, ser_in_l,
    output Q, ser_out_r, ser_out_l, shift_cnt, done
  );

endinterface : universal_shift_reg_if

// File: rtl/universal_shift_reg_ffd.sv
// -----------------------------------------------------------------------------
// ffd_sync_rst
//   1-bit rising-edge D flip-flop with synchronous, active-high reset and a
//   per-instance reset value. Storage cell of the universal shift register.
//   Ports:
//     clk     in  clock
//     rst     in  synchronous reset, active high
//     rst_val in  value taken on reset
//     d       in  next-state input
//     q       out stored bit
// -----------------------------------------------------------------------------
module ffd_sync_rst (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic q_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would let a shift ripple.
  always_ff @(posedge clk) begin
    if (rst) q_q <= rst_val;
    else     q_q <= d;
  end

  assign q = q_q;

endmodule : ffd_sync_rst

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   Parametrised universal shift register: hold, shift right, shift left and
//   parallel load, with optional rotate. Counts shifts since the last load or
//   reset (saturating at WIDTH) and flags done once a full word has shifted.
//   Parameters:
//     WIDTH     register width (>= 2)
//     ROTATE    1: shifted-out bit wraps around, serial inputs ignored
//     RESET_VAL value of Q after reset
//   Ports:
//     clk  in  clock, all state updates on the rising edge
//     rst  in  synchronous reset, active high, overrides every mode
//     bus  slave modport of universal_shift_reg_if (mode, data, serial in/out,
//          Q, shift_cnt, done)
// -----------------------------------------------------------------------------
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter bit               ROTATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  universal_shift_reg_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] q_vec;    // outputs of the flip-flop cells
  logic [WIDTH-1:0] shr_vec;  // candidate value for shift right
  logic [WIDTH-1:0] shl_vec;  // candidate value for shift left
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With ROTATE the outgoing bit re-enters at the opposite end, so the serial
  // inputs are never looked at.
  assign shr_vec = {(ROTATE ? q_vec[0]       : bus.ser_in_r), q_vec[WIDTH-1:1]};
  assign shl_vec = {q_vec[WIDTH-2:0], (ROTATE ? q_vec[WIDTH-1] : bus.ser_in_l)};

  // One 4:1 next-state mux per bit feeding one flip-flop cell (Mano-style stage).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_d;

    // NOTE: the default assignment before the case guarantees bit_d is written
    // on every path, so no latch can be inferred.
    always_comb begin
      bit_d = q_vec[i];
      case (bus.mode)
        MODE_HOLD: bit_d = q_vec[i];
        MODE_SHR:  bit_d = shr_vec[i];
        MODE_SHL:  bit_d = shl_vec[i];
        MODE_LOAD: bit_d = bus.data[i];
        default:   bit_d = q_vec[i];
      endcase
    end

    ffd_sync_rst u_ff (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .d       (bit_d),
      .q       (q_vec[i])
    );
  end

  // Shift counter: cleared by load, bumped by either shift direction,
  // saturating at WIDTH so done stays up until the next load or reset.
  always_comb begin
    cnt_d = cnt_q;
    case (bus.mode)
      MODE_LOAD: cnt_d = '0;
      MODE_SHR, MODE_SHL: begin
        if (cnt_q != CNT_W'(WIDTH)) cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.Q         = q_vec;
  assign bus.ser_out_r = q_vec[0];
  assign bus.ser_out_l = q_vec[WIDTH-1];
  assign bus.shift_cnt = cnt_q;
  assign bus.done      = (cnt_q == CNT_W'(WIDTH));

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//   Directed, table-driven bench for universal_shift_reg at WIDTH=4.
//   u_dut_fill uses serial fill (ROTATE=0), u_dut_rot uses rotate (ROTATE=1).
//   Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;
  import universal_shift_reg_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(W)) bus_fill ();
  universal_shift_reg_if #(.WIDTH(W)) bus_rot ();

  universal_shift_reg #(.WIDTH(W), .ROTATE(1'b0), .RESET_VAL(4'b0000)) u_dut_fill (
    .clk (clk),
    .rst (rst),
    .bus (bus_fill.slave)
  );

  universal_shift_reg #(.WIDTH(W), .ROTATE(1'b1), .RESET_VAL(4'b0000)) u_dut_rot (
    .clk (clk),
    .rst (rst),
    .bus (bus_rot.slave)
  );

  typedef struct {
    logic       rst;
    usr_mode_e  mode;
    logic [3:0] data;
    logic       sir;
    logic       sil;
    logic       chk_pre;   // check ser_out_r before the edge
    logic       pre_sor;
    logic [3:0] exp_q;
    logic [2:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic r, input usr_mode_e m, input logic [3:0] d,
                              input logic sir, input logic sil,
                              input logic cp, input logic ps,
                              input logic [3:0] eq, input logic [2:0] ec,
                              input logic ed);
    vec_t v;
    v.rst = r; v.mode = m; v.data = d; v.sir = sir; v.sil = sil;
    v.chk_pre = cp; v.pre_sor = ps;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  // Checks the complete output set of one DUT against expected Q/cnt/done.
  task automatic check_fill(input string tag, input logic [3:0] eq,
                            input logic [2:0] ec, input logic ed);
    check({tag, " Q"},         32'(bus_fill.Q),         32'(eq));
    check({tag, " shift_cnt"}, 32'(bus_fill.shift_cnt), 32'(ec));
    check({tag, " done"},      32'(bus_fill.done),      32'(ed));
    check({tag, " ser_out_r"}, 32'(bus_fill.ser_out_r), 32'(eq[0]));
    check({tag, " ser_out_l"}, 32'(bus_fill.ser_out_l), 32'(eq[3]));
  endtask

  task automatic check_rot(input string tag, input logic [3:0] eq,
                           input logic [2:0] ec, input logic ed);
    check({tag, " Q"},         32'(bus_rot.Q),         32'(eq));
    check({tag, " shift_cnt"}, 32'(bus_rot.shift_cnt), 32'(ec));
    check({tag, " done"},      32'(bus_rot.done),      32'(ed));
  endtask

  task automatic drive_rot(input logic r, input usr_mode_e m, input logic [3:0] d,
                           input logic sir, input logic sil);
    rst              = r;
    bus_rot.mode     = m;
    bus_rot.data     = d;
    bus_rot.ser_in_r = sir;
    bus_rot.ser_in_l = sil;
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_fill.mode = MODE_HOLD; bus_fill.data = '0;
    bus_fill.ser_in_r = 1'b0;  bus_fill.ser_in_l = 1'b0;
    bus_rot.mode  = MODE_HOLD; bus_rot.data  = '0;
    bus_rot.ser_in_r  = 1'b0;  bus_rot.ser_in_l  = 1'b0;

    //                rst   mode       data     sir   sil   cp    pre   Q        cnt   done
    // reset, then load 1011
    vecs.push_back(mk(1'b1, MODE_HOLD, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_LOAD, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 3'd0, 1'b0));
    // shift right with zero fill; ser_out_r before each edge = 1,1,0,1
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd4, 1'b1));
    // load 0000, then shift left with one fill; counter saturates at 4
    vecs.push_back(mk(1'b0, MODE_LOAD, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b1));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b1));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b1));
    // mixed directions count alike: load 1001, right (fill 0), left (fill 0)
    vecs.push_back(mk(1'b0, MODE_LOAD, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHL,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd2, 1'b0));
    // reset mid-operation wins over load
    vecs.push_back(mk(1'b0, MODE_LOAD, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, MODE_SHR,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 3'd2, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0));
    // load 0110 ahead of the hold sequence
    vecs.push_back(mk(1'b0, MODE_LOAD, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 3'd0, 1'b0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst               = vecs[i].rst;
      bus_fill.mode     = vecs[i].mode;
      bus_fill.data     = vecs[i].data;
      bus_fill.ser_in_r = vecs[i].sir;
      bus_fill.ser_in_l = vecs[i].sil;
      if (vecs[i].chk_pre)
        check($sformatf("vec%0d pre-edge ser_out_r", i),
              32'(bus_fill.ser_out_r), 32'(vecs[i].pre_sor));
      @(posedge clk);
      #1;
      check_fill($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // Hold for 10 edges with toggling serial inputs: nothing may move.
    rst           = 1'b0;
    bus_fill.mode = MODE_HOLD;
    bus_fill.data = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      bus_fill.ser_in_r = k[0];
      bus_fill.ser_in_l = ~k[0];
      @(posedge clk);
      #1;
      check_fill($sformatf("hold%0d", k), 4'b0110, 3'd0, 1'b0);
    end

    // Rotate DUT: serial inputs held at 1 to show they are ignored.
    drive_rot(1'b1, MODE_HOLD, 4'b0000, 1'b1, 1'b1);
    check_rot("rot reset", 4'b0000, 3'd0, 1'b0);
    drive_rot(1'b0, MODE_LOAD, 4'b1000, 1'b1, 1'b1);
    check_rot("rot load", 4'b1000, 3'd0, 1'b0);
    drive_rot(1'b0, MODE_SHR, 4'b0000, 1'b1, 1'b1);
    check_rot("rot shr1", 4'b0100, 3'd1, 1'b0);
    drive_rot(1'b0, MODE_SHR, 4'b0000, 1'b1, 1'b1);
    check_rot("rot shr2", 4'b0010, 3'd2, 1'b0);
    drive_rot(1'b0, MODE_SHR, 4'b0000, 1'b1, 1'b1);
    check_rot("rot shr3", 4'b0001, 3'd3, 1'b0);
    drive_rot(1'b0, MODE_SHR, 4'b0000, 1'b1, 1'b1);
    check_rot("rot shr4", 4'b1000, 3'd4, 1'b1);
    drive_rot(1'b0, MODE_SHL, 4'b0000, 1'b1, 1'b1);
    check_rot("rot shl", 4'b0001, 3'd4, 1'b1);
    drive_rot(1'b0, MODE_LOAD, 4'b0011, 1'b0, 1'b0);
    check_rot("rot reload", 4'b0011, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_universal_shift_reg
